// File: rtl/ttt_board_ctrl_if.sv
// Move-request / board-status bundle between the input decoder, win detector,
// display driver and the tic-tac-toe board controller.
interface ttt_board_ctrl_if;
    logic       new_game;
    logic       move_req;
    logic [3:0] move_sq;
    logic       player_win;

    logic [1:0] square_1_status;
    logic [1:0] square_2_status;
    logic [1:0] square_3_status;
    logic [1:0] square_4_status;
    logic [1:0] square_5_status;
    logic [1:0] square_6_status;
    logic [1:0] square_7_status;
    logic [1:0] square_8_status;
    logic [1:0] square_9_status;

    logic [1:0] cur_player;
    logic       move_ack;
    logic       move_err;
    logic       game_over;
    logic [1:0] winner_id;
    logic [3:0] move_count;

    modport master (
        output new_game, move_req, move_sq, player_win,
        input  square_1_status, square_2_status, square_3_status,
               square_4_status, square_5_status, square_6_status,
               square_7_status, square_8_status, square_9_status,
               cur_player, move_ack, move_err, game_over, winner_id, move_count
    );

    modport slave (
        input  new_game, move_req, move_sq, player_win,
        output square_1_status, square_2_status, square_3_status,
               square_4_status, square_5_status, square_6_status,
               square_7_status, square_8_status, square_9_status,
               cur_player, move_ack, move_err, game_over, winner_id, move_count
    );
endinterface

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe move validator, board register file and TURN/WAIT/DONE game FSM.
// Optional: define ALT_START_EN to alternate the opening player on every new_game.
module ttt_board_ctrl #(
    parameter int FIRST_PLAYER = 1,
    parameter int WIN_WAIT     = 1
) (
    input  logic            clk,
    input  logic            clr_n,
    ttt_board_ctrl_if.slave ctrl_if
);
    typedef enum logic [1:0] {ST_TURN = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

    localparam logic [1:0] FIRST_CODE = (FIRST_PLAYER == 2) ? 2'b10 : 2'b01;
    localparam logic [2:0] WAIT_LOAD  = 3'(WIN_WAIT);
    localparam logic [3:0] MAX_MOVES  = 4'd9;

    state_t          state_q, state_d;
    logic [8:0][1:0] board_q, board_d;
    logic [1:0]      player_q, player_d;
    logic [2:0]      wait_cnt_q, wait_cnt_d;
    logic [3:0]      count_q, count_d;
    logic [1:0]      winner_q, winner_d;
    logic            over_q, over_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;

    logic [8:0]      sq_sel;
    logic [8:0]      sq_empty;
    logic            legal;
    logic [1:0]      start_code;

    // Out-of-range squares (0, 10..15) select nothing, so they are never legal.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_sq
            assign sq_sel[gi]   = (ctrl_if.move_sq == 4'(gi + 1));
            assign sq_empty[gi] = (board_q[gi] == 2'b00);
        end
    endgenerate
    assign legal = |(sq_sel & sq_empty);

`ifdef ALT_START_EN
    logic start_q, start_d;
    assign start_d    = ctrl_if.new_game ? ~start_q : start_q;
    assign start_code = start_d ? ~FIRST_CODE : FIRST_CODE;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) start_q <= 1'b0;
        else        start_q <= start_d;
    end
`else
    assign start_code = FIRST_CODE;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_TURN;
            board_q    <= '0;
            player_q   <= FIRST_CODE;
            wait_cnt_q <= 3'd0;
            count_q    <= 4'd0;
            winner_q   <= 2'b00;
            over_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            player_q   <= player_d;
            wait_cnt_q <= wait_cnt_d;
            count_q    <= count_d;
            winner_q   <= winner_d;
            over_q     <= over_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        player_d   = player_q;
        wait_cnt_d = wait_cnt_q;
        count_d    = count_q;
        winner_d   = winner_q;
        over_d     = over_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        // new_game overrides everything, including a coincident move request.
        if (ctrl_if.new_game) begin
            state_d    = ST_TURN;
            board_d    = '0;
            player_d   = start_code;
            wait_cnt_d = 3'd0;
            count_d    = 4'd0;
            winner_d   = 2'b00;
            over_d     = 1'b0;
        end else begin
            case (state_q)
                ST_TURN: begin
                    if (ctrl_if.move_req) begin
                        if (legal) begin
                            for (int i = 0; i < 9; i++) begin
                                if (sq_sel[i]) board_d[i] = player_q;
                            end
                            count_d    = (count_q == MAX_MOVES) ? count_q : count_q + 4'd1;
                            ack_d      = 1'b1;
                            wait_cnt_d = WAIT_LOAD;
                            state_d    = ST_WAIT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    err_d = ctrl_if.move_req;
                    // Sample the detector only once the counter has drained.
                    if (wait_cnt_q == 3'd0) begin
                        if (ctrl_if.player_win) begin
                            winner_d = player_q;
                            over_d   = 1'b1;
                            player_d = 2'b00;
                            state_d  = ST_DONE;
                        end else if (count_q == MAX_MOVES) begin
                            winner_d = 2'b11;
                            over_d   = 1'b1;
                            player_d = 2'b00;
                            state_d  = ST_DONE;
                        end else begin
                            player_d = ~player_q;
                            state_d  = ST_TURN;
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q - 3'd1;
                    end
                end
                ST_DONE: begin
                    err_d = ctrl_if.move_req;
                end
                default: begin
                    state_d = ST_TURN;
                end
            endcase
        end
    end

    always_comb begin
        ctrl_if.square_1_status = board_q[0];
        ctrl_if.square_2_status = board_q[1];
        ctrl_if.square_3_status = board_q[2];
        ctrl_if.square_4_status = board_q[3];
        ctrl_if.square_5_status = board_q[4];
        ctrl_if.square_6_status = board_q[5];
        ctrl_if.square_7_status = board_q[6];
        ctrl_if.square_8_status = board_q[7];
        ctrl_if.square_9_status = board_q[8];
        ctrl_if.cur_player      = player_q;
        ctrl_if.move_ack        = ack_q;
        ctrl_if.move_err        = err_q;
        ctrl_if.game_over       = over_q;
        ctrl_if.winner_id       = winner_q;
        ctrl_if.move_count      = count_q;
    end
endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Scoreboarded bench for ttt_board_ctrl: WIN_WAIT=1 instance with a line-detector
// model on player_win, plus a WIN_WAIT=3 instance driven directly.
module tb_ttt_board_ctrl;
    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    ttt_board_ctrl_if bus ();
    ttt_board_ctrl_if bus3 ();

    ttt_board_ctrl #(.FIRST_PLAYER(1), .WIN_WAIT(1)) dut  (.clk(clk), .clr_n(clr_n), .ctrl_if(bus));
    ttt_board_ctrl #(.FIRST_PLAYER(1), .WIN_WAIT(3)) dut3 (.clk(clk), .clr_n(clr_n), .ctrl_if(bus3));

    int total = 0;
    int bad   = 0;
    int ng_count = 0;

    typedef struct {
        bit         is_ack;
        logic [3:0] sq;
        logic [1:0] code;
    } exp_t;
    exp_t exp_q[$];

    // Reference three-in-a-row detector over the board outputs.
    localparam int LINES [24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};
    logic [8:0][1:0] brd;
    logic            pw_model;
    assign brd = {bus.square_9_status, bus.square_8_status, bus.square_7_status,
                  bus.square_6_status, bus.square_5_status, bus.square_4_status,
                  bus.square_3_status, bus.square_2_status, bus.square_1_status};
    always_comb begin
        pw_model = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (brd[LINES[3*k]] != 2'b00 && brd[LINES[3*k]] == brd[LINES[3*k+1]] &&
                brd[LINES[3*k]] == brd[LINES[3*k+2]])
                pw_model = 1'b1;
        end
    end
    assign bus.player_win = pw_model;

    function automatic logic [1:0] sq_of(input int i);
        case (i)
            1: return bus.square_1_status;
            2: return bus.square_2_status;
            3: return bus.square_3_status;
            4: return bus.square_4_status;
            5: return bus.square_5_status;
            6: return bus.square_6_status;
            7: return bus.square_7_status;
            8: return bus.square_8_status;
            9: return bus.square_9_status;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] exp_start();
`ifdef ALT_START_EN
        return ng_count[0] ? 2'b10 : 2'b01;
`else
        return 2'b01;
`endif
    endfunction

    // Scoreboard monitor: every ack/err pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.move_ack === 1'b1 || bus.move_err === 1'b1) begin
            total++;
            if (bus.move_ack && bus.move_err) begin
                bad++;
                $display("FAIL ack_err_exclusive: ack=%b err=%b, required only one high", bus.move_ack, bus.move_err);
            end
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_pulse: ack=%b err=%b, required no pulse", bus.move_ack, bus.move_err);
            end else begin
                e = exp_q.pop_front();
                $display("move sq=%0d ack=%b err=%b expect_ack=%b", e.sq, bus.move_ack, bus.move_err, e.is_ack);
                total++;
                if (bus.move_ack !== e.is_ack) begin
                    bad++;
                    $display("FAIL move_result sq=%0d: ack=%b, required ack=%b", e.sq, bus.move_ack, e.is_ack);
                end
                if (e.is_ack) begin
                    total++;
                    if (sq_of(int'(e.sq)) !== e.code) begin
                        bad++;
                        $display("FAIL square_write sq=%0d: got=%b, required=%b", e.sq, sq_of(int'(e.sq)), e.code);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        ng_count = 0;
        exp_q.delete();
    endtask

    task automatic check_drained(input string tag);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_pulse %s: pending=%0d, required 0", tag, exp_q.size());
        end
    endtask

    task automatic do_move(input logic [3:0] sq, input bit legal, input logic [1:0] code);
        exp_t e;
        total++;
        if (bus.cur_player !== code) begin
            bad++;
            $display("FAIL cur_player_before sq=%0d: got=%b, required=%b", sq, bus.cur_player, code);
        end
        e.is_ack = legal; e.sq = sq; e.code = code;
        exp_q.push_back(e);
        bus.move_sq  = sq;
        bus.move_req = 1'b1;
        @(negedge clk);
        bus.move_req = 1'b0;
        if (legal) repeat (2) @(negedge clk);
    endtask

    task automatic wait_over();
        int n = 0;
        while (bus.game_over !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.game_over !== 1'b1) begin
            bad++;
            $display("FAIL game_over_timeout: game_over=%b, required 1", bus.game_over);
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.cur_player !== 2'b01) begin
            bad++; $display("FAIL reset_cur_player: got=%b, required=01", bus.cur_player);
        end
        total++;
        if ({bus.move_ack, bus.move_err, bus.game_over} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: ack/err/over=%b, required 000", {bus.move_ack, bus.move_err, bus.game_over});
        end
        total++;
        if (bus.winner_id !== 2'b00 || bus.move_count !== 4'd0) begin
            bad++; $display("FAIL reset_winner_count: winner=%b count=%0d, required 00/0", bus.winner_id, bus.move_count);
        end
        total++;
        if (brd !== '0) begin
            bad++; $display("FAIL reset_board: got=%h, required 0", brd);
        end
        clr_n = 1'b1;
        ng_count = 0;
        @(negedge clk);
    endtask

    task automatic play_top_row_win();
        do_move(4'd1, 1'b1, 2'b01);
        do_move(4'd4, 1'b1, 2'b10);
        do_move(4'd2, 1'b1, 2'b01);
        do_move(4'd5, 1'b1, 2'b10);
        do_move(4'd3, 1'b1, 2'b01);
        wait_over();
    endtask

    task automatic test_win();
        apply_reset();
        play_top_row_win();
        total++;
        if (bus.winner_id !== 2'b01 || bus.cur_player !== 2'b00) begin
            bad++; $display("FAIL win_result: winner=%b cur=%b, required 01/00", bus.winner_id, bus.cur_player);
        end
        total++;
        if (bus.move_count !== 4'd5) begin
            bad++; $display("FAIL win_count: got=%0d, required 5", bus.move_count);
        end
        total++;
        if ({bus.square_1_status, bus.square_2_status, bus.square_3_status,
             bus.square_4_status, bus.square_5_status} !== 10'b01_01_01_10_10) begin
            bad++; $display("FAIL win_board: got=%h, required 01,01,01,10,10", brd);
        end
        check_drained("win");
    endtask

    task automatic test_illegal();
        apply_reset();
        do_move(4'd5,  1'b1, 2'b01);
        do_move(4'd5,  1'b0, 2'b10);
        do_move(4'd0,  1'b0, 2'b10);
        do_move(4'd12, 1'b0, 2'b10);
        #1;
        total++;
        if (bus.square_5_status !== 2'b01 || bus.cur_player !== 2'b10 || bus.move_count !== 4'd1) begin
            bad++;
            $display("FAIL illegal_state: sq5=%b cur=%b count=%0d, required 01/10/1",
                     bus.square_5_status, bus.cur_player, bus.move_count);
        end
        check_drained("illegal");
    endtask

    task automatic test_draw();
        logic [3:0] seq [9] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'd6, 4'd8, 4'd7, 4'd9};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            do_move(seq[i], 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        wait_over();
        total++;
        if (bus.winner_id !== 2'b11 || bus.move_count !== 4'd9 || bus.cur_player !== 2'b00) begin
            bad++;
            $display("FAIL draw_result: winner=%b count=%0d cur=%b, required 11/9/00",
                     bus.winner_id, bus.move_count, bus.cur_player);
        end
        do_move(4'd1, 1'b0, 2'b00);
        check_drained("draw");
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_move(4'd1, 1'b1, 2'b01);
        do_move(4'd2, 1'b1, 2'b10);
        do_move(4'd4, 1'b1, 2'b01);
        do_move(4'd5, 1'b1, 2'b10);
        total++;
        if (bus.move_count !== 4'd4) begin
            bad++; $display("FAIL async_pre_count: got=%0d, required 4", bus.move_count);
        end
        #2;
        clr_n = 1'b0;
        #1;
        total++;
        if (bus.move_count !== 4'd0 || brd !== '0 || bus.cur_player !== 2'b01) begin
            bad++;
            $display("FAIL async_clear: count=%0d board=%h cur=%b, required 0/0/01",
                     bus.move_count, brd, bus.cur_player);
        end
        @(negedge clk);
        clr_n = 1'b1;
        ng_count = 0;
        do_move(4'd9, 1'b1, 2'b01);
        total++;
        if (bus.square_9_status !== 2'b01 || bus.move_count !== 4'd1) begin
            bad++;
            $display("FAIL async_after: sq9=%b count=%0d, required 01/1", bus.square_9_status, bus.move_count);
        end
        check_drained("async_reset");
    endtask

    task automatic test_new_game_collision();
        apply_reset();
        play_top_row_win();
        bus.new_game = 1'b1;
        bus.move_req = 1'b1;
        bus.move_sq  = 4'd1;
        @(negedge clk);
        bus.new_game = 1'b0;
        bus.move_req = 1'b0;
        ng_count++;
        total++;
        if (bus.move_ack !== 1'b0 || bus.move_err !== 1'b0) begin
            bad++; $display("FAIL collision_pulse: ack=%b err=%b, required 0/0", bus.move_ack, bus.move_err);
        end
        total++;
        if (brd !== '0 || bus.move_count !== 4'd0 || bus.game_over !== 1'b0 || bus.winner_id !== 2'b00) begin
            bad++;
            $display("FAIL collision_clear: board=%h count=%0d over=%b winner=%b, required 0/0/0/00",
                     brd, bus.move_count, bus.game_over, bus.winner_id);
        end
        total++;
        if (bus.cur_player !== exp_start()) begin
            bad++; $display("FAIL collision_start: cur=%b, required=%b", bus.cur_player, exp_start());
        end
`ifdef ALT_START_EN
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        ng_count++;
        total++;
        if (bus.cur_player !== exp_start()) begin
            bad++; $display("FAIL alt_start: cur=%b, required=%b", bus.cur_player, exp_start());
        end
`endif
        check_drained("collision");
    endtask

    task automatic test_win_wait();
        apply_reset();
        bus3.move_sq  = 4'd1;
        bus3.move_req = 1'b1;
        @(negedge clk);
        $display("ww3 move sq=1 ack=%b err=%b", bus3.move_ack, bus3.move_err);
        total++;
        if (bus3.move_ack !== 1'b1 || bus3.move_err !== 1'b0 || bus3.square_1_status !== 2'b01) begin
            bad++;
            $display("FAIL ww3_move: ack=%b err=%b sq1=%b, required 1/0/01",
                     bus3.move_ack, bus3.move_err, bus3.square_1_status);
        end
        bus3.player_win = 1'b1;
        bus3.move_sq    = 4'd2;
        @(negedge clk);
        bus3.player_win = 1'b0;
        bus3.move_req   = 1'b0;
        $display("ww3 move sq=2 ack=%b err=%b", bus3.move_ack, bus3.move_err);
        total++;
        if (bus3.move_err !== 1'b1 || bus3.move_ack !== 1'b0 || bus3.square_2_status !== 2'b00) begin
            bad++;
            $display("FAIL ww3_wait_reject: ack=%b err=%b sq2=%b, required 0/1/00",
                     bus3.move_ack, bus3.move_err, bus3.square_2_status);
        end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (bus3.cur_player !== ((k == 4) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL ww3_turn edge=%0d: cur=%b, required=%b", k, bus3.cur_player,
                         (k == 4) ? 2'b10 : 2'b01);
            end
        end
        total++;
        if (bus3.game_over !== 1'b0 || bus3.winner_id !== 2'b00 || bus3.move_count !== 4'd1) begin
            bad++;
            $display("FAIL ww3_no_win: over=%b winner=%b count=%0d, required 0/00/1",
                     bus3.game_over, bus3.winner_id, bus3.move_count);
        end
    endtask

    initial begin
        clr_n           = 1'b0;
        bus.new_game    = 1'b0;
        bus.move_req    = 1'b0;
        bus.move_sq     = 4'd0;
        bus3.new_game   = 1'b0;
        bus3.move_req   = 1'b0;
        bus3.move_sq    = 4'd0;
        bus3.player_win = 1'b0;
        test_reset();
        test_win();
        test_illegal();
        test_draw();
        test_async_reset();
        test_new_game_collision();
        test_win_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
